// File: rtl/nes_pkg.sv
// Shared NES core definitions: OAM DMA state encoding and fixed bus addresses.
`timescale 1ns/1ps
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam logic [4:0]  OAM_DMA_REG  = 5'h14;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a write to $4014 halts the CPU and copies page $XX00-$XXFF into OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so the first read lands on a get cycle.
`timescale 1ns/1ps
module oam_dma
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1_rising,
  input  logic        ph1_falling,
  input  logic        ph2_rising,
  input  logic        ph2_falling,
  input  logic [4:0]  io_mem_addr,
  input  logic        io_mem_ncs,
  input  logic        io_mem_rnw,
  input  logic [7:0]  io_mem_din,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_mem_addr,
  output logic        dma_mem_rnw,
  output logic [7:0]  dma_mem_dout,
  input  logic [7:0]  dma_mem_din
);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic       parity;
  logic       trigger;
  logic       align_needed;
  logic       unused_strobes;

  assign unused_strobes = ^{ph1_rising, ph1_falling, ph2_rising};

  assign trigger = !io_mem_ncs && !io_mem_rnw && (io_mem_addr == OAM_DMA_REG);

  // parity holds the current (HALT) cycle; 0 now means the next cycle is a put cycle
`ifdef OAM_DMA_ALIGN_EN
  assign align_needed = ~parity;
`else
  assign align_needed = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      page         <= '0;
      idx          <= '0;
      parity       <= 1'b0;
      cpu_rdy      <= 1'b1;
      dma_active   <= 1'b0;
      dma_mem_addr <= '0;
      dma_mem_rnw  <= 1'b1;
      dma_mem_dout <= '0;
    end else if (ph2_falling) begin
      parity <= ~parity;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            page         <= io_mem_din;
            idx          <= '0;
            state        <= ST_HALT;
            cpu_rdy      <= 1'b0;
            dma_active   <= 1'b1;
            dma_mem_addr <= {io_mem_din, 8'h00};
            dma_mem_rnw  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (align_needed) begin
            state        <= ST_ALIGN;
            dma_mem_addr <= {page, 8'h00};
          end else begin
            state        <= ST_READ;
            dma_mem_addr <= {page, idx};
          end
        end
        ST_ALIGN: begin
          state        <= ST_READ;
          dma_mem_addr <= {page, idx};
        end
        ST_READ: begin
          dma_mem_dout <= dma_mem_din;
          state        <= ST_WRITE;
          dma_mem_addr <= OAMDATA_ADDR;
          dma_mem_rnw  <= 1'b0;
        end
        ST_WRITE: begin
          idx         <= idx + 8'd1;
          dma_mem_rnw <= 1'b1;
          if (idx == 8'hFF) begin
            state      <= ST_IDLE;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
          end else begin
            state        <= ST_READ;
            dma_mem_addr <= {page, idx + 8'd1};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
